loop_unroll_seq: RTL and testbench
==================================

Name: loop_unroll_seq

Overview:
Sequencer that runs loop-unroll dispatch after a Loop Address Table (LAT) hit. It tracks unroll iterations over the 4-wide fetch bundle (four 16-bit PCs), and masks instructions past the loop end. It stalls fetch when the loop buffer window fills and redirects fetch to the fallthrough address when unrolling completes. It sits between the LAT lookup and the fetch/interpreter stages; a mispredict aborts it.

Parameters:
WINDOW, 64, loop-buffer instruction capacity; a full window stalls fetch
ADDR_W, 16, per-slot PC width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
hit_valid_in  in  1  LAT hit on bundle slot 0 this cycle
hit_fallthrough_in  in  16  fallthrough address of the hit entry
hit_max_unroll_in  in  7  unroll count of the hit entry
pc_in  in  64  bundle PCs; slot0=[63:48], slot1=[47:32], slot2=[31:16], slot3=[15:0]
bundle_valid_in  in  1  fetch presents a bundle this cycle
credit_rtn_in  in  1  loop buffer drained; window freed
mis_pred_in  in  1  mispredict; abort
lbd_state_out  out  2  FSM state
loop_strt_out  out  1  one-cycle pulse on dispatch start
inst_valid_out  out  4  slot valid mask, MSB=slot0
stll_ftch_out  out  1  stall fetch
fnsh_unrll_out  out  1  one-cycle pulse, unroll finished
redir_valid_out  out  1  one-cycle fetch redirect
redir_addr_out  out  16  redirect target (latched fallthrough)
iter_left_out  out  7  remaining iterations
perf_loops_out  out  16  loops started (only with LOOP_SEQ_PERF_CNT_EN)
perf_aborts_out  out  16  mispredict aborts (only with LOOP_SEQ_PERF_CNT_EN)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - All registered outputs are 0: redir_addr_out=0, iter_left_out=0, perf counters=0.
  - Window count is 0.
  - inst_valid_out=4'b1111, because it is combinational and the state is IDLE.
- States: IDLE=2'b00, DISPATCH=2'b10, STALL=2'b11. 2'b01 is reserved for LAT TRAIN and is never entered here.
- End-of-body match: slot i matches when pc slot i == fallthrough-1 (16-bit wrap, so fallthrough 0 matches 16'hFFFF). The first matching slot from slot0 wins.
  - Mask: slot0→1000, slot1→1100, slot2→1110, slot3→1111.
  - Count: 1/2/3/4 instructions.
  - No match: mask 1111, count 4.
- IDLE:
  - inst_valid_out=1111.
  - Start condition: hit_valid_in & bundle_valid_in & hit_max_unroll_in!=0. On start, next cycle:
    - latch fallthrough and iter_left=hit_max_unroll_in;
    - clear window count;
    - loop_strt_out=1 for one cycle;
    - go to DISPATCH.
  - A hit with max_unroll==0 is ignored.
- DISPATCH:
  - inst_valid_out is combinational from pc_in and the latched fallthrough; it is 0000 when bundle_valid_in=0.
  - Per valid bundle, window count += count.
  - If a slot matched: iter_left-1.
    - If iter_left was 1: next cycle fnsh_unrll_out=1, redir_valid_out=1, redir_addr_out=fallthrough; go to IDLE.
  - Else, if the new window count >= WINDOW: go to STALL.
  - Finish takes priority over stall.
- STALL:
  - stll_ftch_out=1 (registered, asserted the cycle STALL is entered); inst_valid_out=0000.
  - credit_rtn_in: window count=0, go to DISPATCH; stll_ftch_out drops the same edge.
- mis_pred_in, in any state: next state IDLE; all counters, stall and iter_left clear. It overrides simultaneous finish, start and credit; no fnsh or redirect pulse is produced.
- Window count is 7 bits and saturates at 127.
- Latency: output pulses appear one cycle after the triggering edge inputs.

Optional Feature:
LOOP_SEQ_PERF_CNT_EN.
- Defined: perf_loops_out increments on each loop_strt_out; perf_aborts_out increments on each mis_pred_in seen in DISPATCH or STALL. Both are 16-bit and wrap.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
Shared package lat_pkg:
- state encodings (IDLE/TRAIN/DISPATCH/STALL);
- slot bit-field offsets;
- LAT entry field widths (addr 16, num_insts 7, max_unroll 7).

One sub-module, slot_end_enc: combinational match of 4 PCs against fallthrough-1, producing mask[3:0] and count[2:0].

Test Plan:
1. Hit, fallthrough=0x0014, max_unroll=2, bundles 0x10..0x13 twice → loop_strt_out pulse; iter_left 2→1→0; fnsh and redir pulse with addr 0x0014; state returns to 00.
2. End at slot1 (pc 0x20,0x21,0x22,0x23, fallthrough 0x22) → inst_valid_out=1100; count+2.
3. Loop body 4-wide, max_unroll=20, no credit → after 16 bundles stll_ftch_out=1 and state=11; credit_rtn_in → state=10, stall clears.
4. mis_pred_in in the same cycle as the final end-match → IDLE; no fnsh/redir pulse; iter_left=0.
5. Hit with max_unroll=0 → stays IDLE; no loop_strt_out.
6. rst=0 asserted mid-STALL (asynchronous) → stll_ftch_out=0 immediately, state=00; with the macro, perf counters read 0.

Source files
------------

// File: rtl/lat_pkg.sv
// Shared Loop Address Table definitions: sequencer state encodings,
// fetch-bundle slot offsets and LAT entry field widths.
package lat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_TRAIN    = 2'b01,
    ST_DISPATCH = 2'b10,
    ST_STALL    = 2'b11
  } lbd_state_e;

  localparam int LAT_ADDR_W       = 16;
  localparam int LAT_NUM_INSTS_W  = 7;
  localparam int LAT_MAX_UNROLL_W = 7;

  localparam int NUM_SLOTS = 4;

  // Slot 0 is the oldest instruction and sits in the most significant bits.
  localparam int SLOT0_LSB = 48;
  localparam int SLOT1_LSB = 32;
  localparam int SLOT2_LSB = 16;
  localparam int SLOT3_LSB = 0;

endpackage

// File: rtl/slot_end_enc.sv
// Finds the first bundle slot holding the loop-end PC (fallthrough-1).
// Purely combinational; mask keeps slots up to and including the match.
module slot_end_enc #(
  parameter int ADDR_W = 16
) (
  input  logic [4*ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0]   fallthrough,
  output logic [3:0]          mask,
  output logic [2:0]          count,
  output logic                end_hit
);

  logic [ADDR_W-1:0] end_pc;
  logic [3:0]        slot_eq;

  // Fallthrough 0 wraps to an end PC of all-ones.
  assign end_pc = fallthrough - ADDR_W'(1);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      slot_eq[i] = (pc[(3-i)*ADDR_W +: ADDR_W] == end_pc);
    end
  end

  always_comb begin
    mask    = 4'b1111;
    count   = 3'd4;
    end_hit = 1'b1;
    if (slot_eq[0]) begin
      mask  = 4'b1000;
      count = 3'd1;
    end else if (slot_eq[1]) begin
      mask  = 4'b1100;
      count = 3'd2;
    end else if (slot_eq[2]) begin
      mask  = 4'b1110;
      count = 3'd3;
    end else if (!slot_eq[3]) begin
      end_hit = 1'b0;
    end
  end

endmodule

// File: rtl/loop_unroll_seq.sv
// Loop-unroll dispatch sequencer; pulses appear one cycle after their trigger, a full window
// stalls fetch until credit return. Optional perf counters: LOOP_SEQ_PERF_CNT_EN.
module loop_unroll_seq
  import lat_pkg::*;
#(
  parameter int WINDOW = 64,
  parameter int ADDR_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hit_valid_in,
  input  logic [ADDR_W-1:0]           hit_fallthrough_in,
  input  logic [LAT_MAX_UNROLL_W-1:0] hit_max_unroll_in,
  input  logic [4*ADDR_W-1:0]         pc_in,
  input  logic                        bundle_valid_in,
  input  logic                        credit_rtn_in,
  input  logic                        mis_pred_in,
  output logic [1:0]                  lbd_state_out,
  output logic                        loop_strt_out,
  output logic [3:0]                  inst_valid_out,
  output logic                        stll_ftch_out,
  output logic                        fnsh_unrll_out,
  output logic                        redir_valid_out,
  output logic [ADDR_W-1:0]           redir_addr_out,
  output logic [LAT_MAX_UNROLL_W-1:0] iter_left_out,
  output logic [15:0]                 perf_loops_out,
  output logic [15:0]                 perf_aborts_out
);

  localparam logic [6:0] WIN_LIM = 7'(WINDOW);

  lbd_state_e                  state_q, state_d;
  logic [6:0]                  win_q, win_d;
  logic [LAT_MAX_UNROLL_W-1:0] iter_q, iter_d;
  logic [ADDR_W-1:0]           ft_q, ft_d;
  logic [ADDR_W-1:0]           redir_addr_q, redir_addr_d;
  logic                        strt_q, strt_d;
  logic                        fnsh_q, fnsh_d;
  logic                        redir_vld_q, redir_vld_d;
  logic                        stll_q, stll_d;

  logic [3:0] enc_mask;
  logic [2:0] enc_cnt;
  logic       enc_hit;
  logic [7:0] win_raw;
  logic [6:0] win_sum;
  logic       start;
  logic       finishing;

  slot_end_enc #(.ADDR_W(ADDR_W)) u_enc (
    .pc          (pc_in),
    .fallthrough (ft_q),
    .mask        (enc_mask),
    .count       (enc_cnt),
    .end_hit     (enc_hit)
  );

  assign start   = hit_valid_in & bundle_valid_in & (hit_max_unroll_in != '0);
  assign win_raw = {1'b0, win_q} + {5'b0, enc_cnt};
  assign win_sum = win_raw[7] ? 7'h7F : win_raw[6:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      win_q        <= '0;
      iter_q       <= '0;
      ft_q         <= '0;
      redir_addr_q <= '0;
      strt_q       <= 1'b0;
      fnsh_q       <= 1'b0;
      redir_vld_q  <= 1'b0;
      stll_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      iter_q       <= iter_d;
      ft_q         <= ft_d;
      redir_addr_q <= redir_addr_d;
      strt_q       <= strt_d;
      fnsh_q       <= fnsh_d;
      redir_vld_q  <= redir_vld_d;
      stll_q       <= stll_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    iter_d       = iter_q;
    ft_d         = ft_q;
    redir_addr_d = redir_addr_q;
    strt_d       = 1'b0;
    fnsh_d       = 1'b0;
    redir_vld_d  = 1'b0;
    stll_d       = stll_q;
    finishing    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DISPATCH;
          ft_d    = hit_fallthrough_in;
          iter_d  = hit_max_unroll_in;
          win_d   = '0;
          strt_d  = 1'b1;
        end
      end
      ST_DISPATCH: begin
        if (bundle_valid_in) begin
          win_d = win_sum;
          if (enc_hit) begin
            iter_d = iter_q - 1'b1;
            // Last iteration wins over a simultaneously full window.
            if (iter_q == LAT_MAX_UNROLL_W'(1)) begin
              finishing    = 1'b1;
              state_d      = ST_IDLE;
              fnsh_d       = 1'b1;
              redir_vld_d  = 1'b1;
              redir_addr_d = ft_q;
            end
          end
          if (!finishing && (win_sum >= WIN_LIM)) begin
            state_d = ST_STALL;
            stll_d  = 1'b1;
          end
        end
      end
      ST_STALL: begin
        if (credit_rtn_in) begin
          state_d = ST_DISPATCH;
          win_d   = '0;
          stll_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort beats finish, start and credit; no redirect is issued.
    if (mis_pred_in) begin
      state_d      = ST_IDLE;
      win_d        = '0;
      iter_d       = '0;
      stll_d       = 1'b0;
      strt_d       = 1'b0;
      fnsh_d       = 1'b0;
      redir_vld_d  = 1'b0;
      redir_addr_d = redir_addr_q;
    end
  end

  always_comb begin
    inst_valid_out = 4'b0000;
    case (state_q)
      ST_IDLE:     inst_valid_out = 4'b1111;
      ST_DISPATCH: inst_valid_out = bundle_valid_in ? enc_mask : 4'b0000;
      default:     inst_valid_out = 4'b0000;
    endcase
  end

  assign lbd_state_out   = state_q;
  assign loop_strt_out   = strt_q;
  assign stll_ftch_out   = stll_q;
  assign fnsh_unrll_out  = fnsh_q;
  assign redir_valid_out = redir_vld_q;
  assign redir_addr_out  = redir_addr_q;
  assign iter_left_out   = iter_q;

`ifdef LOOP_SEQ_PERF_CNT_EN
  logic [15:0] perf_loops_q;
  logic [15:0] perf_aborts_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_loops_q  <= '0;
      perf_aborts_q <= '0;
    end else begin
      if (strt_q) perf_loops_q <= perf_loops_q + 16'd1;
      if (mis_pred_in && (state_q == ST_DISPATCH || state_q == ST_STALL))
        perf_aborts_q <= perf_aborts_q + 16'd1;
    end
  end

  assign perf_loops_out  = perf_loops_q;
  assign perf_aborts_out = perf_aborts_q;
`else
  assign perf_loops_out  = 16'd0;
  assign perf_aborts_out = 16'd0;
`endif

endmodule

// File: tb/tb_loop_unroll_seq.sv
// Directed bench for loop_unroll_seq with hand-computed expectations.
module tb_loop_unroll_seq;

  logic        clk;
  logic        rst;
  logic        hit_valid_in;
  logic [15:0] hit_fallthrough_in;
  logic [6:0]  hit_max_unroll_in;
  logic [63:0] pc_in;
  logic        bundle_valid_in;
  logic        credit_rtn_in;
  logic        mis_pred_in;
  logic [1:0]  lbd_state_out;
  logic        loop_strt_out;
  logic [3:0]  inst_valid_out;
  logic        stll_ftch_out;
  logic        fnsh_unrll_out;
  logic        redir_valid_out;
  logic [15:0] redir_addr_out;
  logic [6:0]  iter_left_out;
  logic [15:0] perf_loops_out;
  logic [15:0] perf_aborts_out;

  int checks = 0;
  int errors = 0;

  loop_unroll_seq dut (
    .clk                (clk),
    .rst                (rst),
    .hit_valid_in       (hit_valid_in),
    .hit_fallthrough_in (hit_fallthrough_in),
    .hit_max_unroll_in  (hit_max_unroll_in),
    .pc_in              (pc_in),
    .bundle_valid_in    (bundle_valid_in),
    .credit_rtn_in      (credit_rtn_in),
    .mis_pred_in        (mis_pred_in),
    .lbd_state_out      (lbd_state_out),
    .loop_strt_out      (loop_strt_out),
    .inst_valid_out     (inst_valid_out),
    .stll_ftch_out      (stll_ftch_out),
    .fnsh_unrll_out     (fnsh_unrll_out),
    .redir_valid_out    (redir_valid_out),
    .redir_addr_out     (redir_addr_out),
    .iter_left_out      (iter_left_out),
    .perf_loops_out     (perf_loops_out),
    .perf_aborts_out    (perf_aborts_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                = 1'b0;
    hit_valid_in       = 1'b0;
    hit_fallthrough_in = 16'h0;
    hit_max_unroll_in  = 7'd0;
    pc_in              = 64'h0;
    bundle_valid_in    = 1'b0;
    credit_rtn_in      = 1'b0;
    mis_pred_in        = 1'b0;
    #12;
    chk("rst_state", lbd_state_out, 2'b00);
    chk("rst_iter", iter_left_out, 7'd0);
    chk("rst_redir_addr", redir_addr_out, 16'h0);
    chk("rst_mask", inst_valid_out, 4'b1111);
    chk("rst_stall", stll_ftch_out, 1'b0);
    chk("rst_perf_loops", perf_loops_out, 16'd0);
    chk("rst_perf_aborts", perf_aborts_out, 16'd0);
    rst = 1'b1;
    tick();

    // Zero-unroll hit is ignored.
    hit_valid_in       = 1'b1;
    hit_fallthrough_in = 16'h0014;
    hit_max_unroll_in  = 7'd0;
    pc_in              = 64'h0010_0011_0012_0013;
    bundle_valid_in    = 1'b1;
    tick();
    chk("zero_unroll_state", lbd_state_out, 2'b00);
    chk("zero_unroll_strt", loop_strt_out, 1'b0);

    // Basic two-iteration unroll ending in a redirect.
    hit_max_unroll_in = 7'd2;
    #1;
    chk("idle_mask", inst_valid_out, 4'b1111);
    tick();
    hit_valid_in = 1'b0;
    chk("t1_strt", loop_strt_out, 1'b1);
    chk("t1_state", lbd_state_out, 2'b10);
    chk("t1_iter2", iter_left_out, 7'd2);
    chk("t1_mask_slot3", inst_valid_out, 4'b1111);
    tick();
    chk("t1_iter1", iter_left_out, 7'd1);
    chk("t1_strt_drop", loop_strt_out, 1'b0);
    chk("t1_no_fnsh", fnsh_unrll_out, 1'b0);
    tick();
    bundle_valid_in = 1'b0;
    chk("t1_fnsh", fnsh_unrll_out, 1'b1);
    chk("t1_redir", redir_valid_out, 1'b1);
    chk("t1_redir_addr", redir_addr_out, 16'h0014);
    chk("t1_iter0", iter_left_out, 7'd0);
    chk("t1_idle", lbd_state_out, 2'b00);
    tick();
    chk("t1_fnsh_drop", fnsh_unrll_out, 1'b0);
    chk("t1_redir_drop", redir_valid_out, 1'b0);

    // End at slot1, then mispredict on the final end-match.
    hit_valid_in       = 1'b1;
    hit_fallthrough_in = 16'h0022;
    hit_max_unroll_in  = 7'd3;
    pc_in              = 64'h0020_0021_0022_0023;
    bundle_valid_in    = 1'b1;
    tick();
    hit_valid_in    = 1'b0;
    bundle_valid_in = 1'b0;
    #1;
    chk("t2_iter3", iter_left_out, 7'd3);
    chk("t2_mask_nobundle", inst_valid_out, 4'b0000);
    bundle_valid_in = 1'b1;
    #1;
    chk("t2_mask_slot1", inst_valid_out, 4'b1100);
    tick();
    tick();
    chk("t4_iter1", iter_left_out, 7'd1);
    mis_pred_in = 1'b1;
    tick();
    mis_pred_in = 1'b0;
    chk("t4_state", lbd_state_out, 2'b00);
    chk("t4_no_fnsh", fnsh_unrll_out, 1'b0);
    chk("t4_no_redir", redir_valid_out, 1'b0);
    chk("t4_iter0", iter_left_out, 7'd0);

    // Fallthrough 0 wraps: end PC is 0xFFFF in slot1.
    hit_valid_in       = 1'b1;
    hit_fallthrough_in = 16'h0000;
    hit_max_unroll_in  = 7'd1;
    pc_in              = 64'hFFFE_FFFF_0000_0001;
    tick();
    hit_valid_in = 1'b0;
    chk("wrap_state", lbd_state_out, 2'b10);
    chk("wrap_mask", inst_valid_out, 4'b1100);
    tick();
    chk("wrap_fnsh", fnsh_unrll_out, 1'b1);
    chk("wrap_redir_addr", redir_addr_out, 16'h0000);
    chk("wrap_idle", lbd_state_out, 2'b00);

    // Window fill: 16 four-wide bodies reach 64 and stall.
    hit_valid_in       = 1'b1;
    hit_fallthrough_in = 16'h0034;
    hit_max_unroll_in  = 7'd20;
    pc_in              = 64'h0030_0031_0032_0033;
    tick();
    hit_valid_in = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("t3_pre_stall_state", lbd_state_out, 2'b10);
    chk("t3_pre_stall", stll_ftch_out, 1'b0);
    tick();
    chk("t3_stall_state", lbd_state_out, 2'b11);
    chk("t3_stall", stll_ftch_out, 1'b1);
    chk("t3_iter4", iter_left_out, 7'd4);
    chk("t3_stall_mask", inst_valid_out, 4'b0000);
    tick();
    chk("t3_hold_state", lbd_state_out, 2'b11);
    chk("t3_hold_iter", iter_left_out, 7'd4);
    credit_rtn_in = 1'b1;
    tick();
    credit_rtn_in = 1'b0;
    chk("t3_credit_state", lbd_state_out, 2'b10);
    chk("t3_credit_stall", stll_ftch_out, 1'b0);

    // 15 unmatched bundles (60) + two 2-wide bundles: stall only at 64.
    pc_in = 64'h0040_0041_0042_0043;
    for (int i = 0; i < 15; i++) tick();
    chk("t3_nomatch_iter", iter_left_out, 7'd4);
    pc_in = 64'h0032_0033_0034_0035;
    #1;
    chk("t3_mask_slot1", inst_valid_out, 4'b1100);
    tick();
    chk("t3_62_state", lbd_state_out, 2'b10);
    chk("t3_62_iter", iter_left_out, 7'd3);
    tick();
    chk("t3_64_state", lbd_state_out, 2'b11);
    chk("t3_64_iter", iter_left_out, 7'd2);
`ifdef LOOP_SEQ_PERF_CNT_EN
    chk("perf_loops", perf_loops_out, 16'd4);
    chk("perf_aborts", perf_aborts_out, 16'd1);
`endif

    // Asynchronous reset mid-stall.
    #2;
    rst = 1'b0;
    #1;
    chk("arst_stall", stll_ftch_out, 1'b0);
    chk("arst_state", lbd_state_out, 2'b00);
    chk("arst_iter", iter_left_out, 7'd0);
    chk("arst_perf_loops", perf_loops_out, 16'd0);
    chk("arst_perf_aborts", perf_aborts_out, 16'd0);
    bundle_valid_in = 1'b0;
    #10;
    rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
